pe_result_collector: RTL and testbench

PE_RESULT_COLLECTOR -- requirements
Module: pe_result_collector

---
 rtl/pe_result_collector.sv | 141 ++++++++++++++
 tb/tb_pe_result_collector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// Sequences a systolic PE array through accumulate and shift phases, then
// collects the N shifted-out results into a FIFO and streams them downstream.
module pe_result_collector #(
   parameter int N      = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        k_len,
   output logic              mode_out,
   input  logic [DATA_W-1:0] chain_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int PTR_W = $clog2(N);
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [7:0]        k_cnt, k_cnt_nxt;
   logic [PTR_W-1:0]  d_cnt, d_cnt_nxt;
   logic [PTR_W-1:0]  p_cnt, p_cnt_nxt;
   logic [PTR_W-1:0]  wptr, wptr_nxt;
   logic [PTR_W-1:0]  rptr, rptr_nxt;
   logic [CNT_W-1:0]  fill, fill_nxt, fill_after_pop;
   logic [DATA_W-1:0] mem [N];
   logic [DATA_W-1:0] data_nxt;
   logic              push, pop;
   logic              mode_nxt, busy_nxt, done_nxt, valid_nxt, last_nxt;

   // Pointers and per-job counters wrap modulo N, so N need not be a power of two.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state_nxt = state;
      k_cnt_nxt = k_cnt;
      d_cnt_nxt = d_cnt;
      push      = 1'b0;
      done_nxt  = 1'b0;
      pop       = out_valid & out_ready;

      case (state)
         IDLE: begin
            if (start) begin
               d_cnt_nxt = '0;
               if (k_len != 8'd0) begin
                  state_nxt = COMPUTE;
                  k_cnt_nxt = k_len - 8'd1;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         COMPUTE: begin
            if (k_cnt == 8'd0) state_nxt = DRAIN;
            else               k_cnt_nxt = k_cnt - 8'd1;
         end
         DRAIN: begin
            push = 1'b1;
            if (d_cnt == LAST_IDX) begin
               state_nxt = FLUSH;
               d_cnt_nxt = '0;
            end else begin
               d_cnt_nxt = wrap_inc(d_cnt);
            end
         end
         FLUSH: begin
            if (pop && p_cnt == LAST_IDX) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      p_cnt_nxt      = pop  ? wrap_inc(p_cnt) : p_cnt;
      rptr_nxt       = pop  ? wrap_inc(rptr)  : rptr;
      wptr_nxt       = push ? wrap_inc(wptr)  : wptr;
      fill_after_pop = fill - CNT_W'(pop);
      fill_nxt       = fill_after_pop + CNT_W'(push);

      // The output register always mirrors the word the FIFO head will hold next
      // cycle; a word written into an otherwise empty FIFO bypasses the array.
      data_nxt = out_data;
      if (fill_after_pop != '0)  data_nxt = mem[rptr_nxt];
      else if (push)             data_nxt = chain_in;

      valid_nxt = (fill_nxt != '0);
      last_nxt  = valid_nxt && (p_cnt_nxt == LAST_IDX);
      mode_nxt  = (state_nxt == DRAIN);
      busy_nxt  = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         k_cnt     <= '0;
         d_cnt     <= '0;
         p_cnt     <= '0;
         wptr      <= '0;
         rptr      <= '0;
         fill      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         mode_out  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         k_cnt     <= k_cnt_nxt;
         d_cnt     <= d_cnt_nxt;
         p_cnt     <= p_cnt_nxt;
         wptr      <= wptr_nxt;
         rptr      <= rptr_nxt;
         fill      <= fill_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
         mode_out  <= mode_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Storage array has no reset; emptiness is tracked by the pointers and fill count.
   always_ff @(posedge clk) begin
      if (rst && push) mem[wptr] <= chain_in;
   end

endmodule

// File: tb/tb_pe_result_collector.sv
// Self-checking bench for pe_result_collector (N=4, DATA_W=8) using a
// scoreboard of expected {last, data} words checked as they are popped.
module tb_pe_result_collector;

   localparam int N = 4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] k_len;
   logic       mode_out;
   logic [7:0] chain_in;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;

   int pass_cnt = 0;
   int total    = 0;
   logic [8:0] exp_q [$];

   pe_result_collector #(.N(N), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .mode_out(mode_out),
      .chain_in(chain_in), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every accepted word is compared against the oldest expectation.
   always begin
      @(negedge clk);
      #1;
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("[TB] FAIL unexpected_word got %h exp none", out_data);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if (out_data !== e[7:0] || out_last !== e[8])
               $display("[TB] FAIL word got data=%h last=%b exp data=%h last=%b",
                        out_data, out_last, e[7:0], e[8]);
            else pass_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout exp finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Runs one job from a negedge: K compute cycles, N drain cycles, then waits
   // for done. hold>0 keeps out_ready low for that many cycles after DRAIN.
   task automatic run_job(input int k, input logic [7:0] base, input int hold,
                          output int lat);
      out_ready = (hold == 0);
      start = 1'b1;
      k_len = 8'(k);
      @(negedge clk);
      start = 1'b0;
      k_len = 8'd0;
      for (int i = 0; i < k; i++) begin
         total++;
         if (mode_out !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL compute_cycle%0d got mode=%b busy=%b done=%b exp 0/1/0",
                     i, mode_out, busy, done);
         else pass_cnt++;
         @(negedge clk);
      end
      for (int j = 0; j < N; j++) begin
         total++;
         if (mode_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL drain_cycle%0d got mode=%b busy=%b done=%b exp 1/1/0",
                     j, mode_out, busy, done);
         else pass_cnt++;
         chain_in = base + 8'(j);
         exp_q.push_back({(j == N - 1), base + 8'(j)});
         @(negedge clk);
      end
      total++;
      if (mode_out !== 1'b0 || busy !== 1'b1)
         $display("[TB] FAIL flush_entry got mode=%b busy=%b exp 0/1", mode_out, busy);
      else pass_cnt++;
      for (int h = 0; h < hold; h++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== base || out_last !== 1'b0)
            $display("[TB] FAIL hold%0d got valid=%b data=%h last=%b exp 1/%h/0",
                     h, out_valid, out_data, out_last, base);
         else pass_cnt++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done !== 1'b1 && lat < 50);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0)
         $display("[TB] FAIL job_done got done=%b busy=%b valid=%b left=%0d exp 1/0/0/0",
                  done, busy, out_valid, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b1;
      k_len = 8'd3;
      out_ready = 1'b1;
      chain_in = 8'h00;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if (mode_out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
             done !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00)
            $display("[TB] FAIL reset got mode=%b valid=%b busy=%b done=%b last=%b data=%h exp all 0",
                     mode_out, out_valid, busy, done, out_last, out_data);
         else pass_cnt++;
      end
      rst = 1'b1;
      start = 1'b0;
      k_len = 8'd0;
   endtask

   task automatic test_nominal();
      int lat;
      run_job(3, 8'h11, 0, lat);
      total++;
      if (lat !== 1) $display("[TB] FAIL nominal_done_latency got %0d exp 1", lat);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int lat;
      run_job(3, 8'h11, 3, lat);
      total++;
      if (lat !== 4) $display("[TB] FAIL backpressure_done_latency got %0d exp 4", lat);
      else pass_cnt++;
   endtask

   task automatic test_zero_length();
      int lat;
      run_job(0, 8'h60, 0, lat);
      total++;
      if (lat !== 1) $display("[TB] FAIL zero_done_latency got %0d exp 1", lat);
      else pass_cnt++;
   endtask

   task automatic test_long_k();
      int lat;
      run_job(255, 8'h70, 0, lat);
      total++;
      if (lat !== 1) $display("[TB] FAIL long_done_latency got %0d exp 1", lat);
      else pass_cnt++;
   endtask

   task automatic test_illegal_start_reset();
      out_ready = 1'b0;
      start = 1'b1;
      k_len = 8'd2;
      @(negedge clk);
      start = 1'b1;
      k_len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (mode_out !== 1'b0 || busy !== 1'b1)
         $display("[TB] FAIL ignored_start got mode=%b busy=%b exp 0/1", mode_out, busy);
      else pass_cnt++;
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
         total++;
         if (mode_out !== 1'b1)
            $display("[TB] FAIL abort_drain%0d got mode=%b exp 1", j, mode_out);
         else pass_cnt++;
         chain_in = 8'hC0 + 8'(j);
         @(negedge clk);
      end
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hC0)
         $display("[TB] FAIL abort_captured got valid=%b data=%h exp 1/c0", out_valid, out_data);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || mode_out !== 1'b0 || done !== 1'b0 ||
          out_data !== 8'h00)
         $display("[TB] FAIL midjob_reset got valid=%b busy=%b mode=%b done=%b data=%h exp 0/0/0/0/00",
                  out_valid, busy, mode_out, done, out_data);
      else pass_cnt++;
      rst = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL post_abort got done=%b valid=%b busy=%b exp 0/0/0",
                     done, out_valid, busy);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_job(1, 8'hA0, 0, lat);
      run_job(2, 8'hB0, 0, lat);
      total++;
      if (lat !== 1) $display("[TB] FAIL b2b_done_latency got %0d exp 1", lat);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      @(negedge clk);
      test_backpressure();
      @(negedge clk);
      test_zero_length();
      @(negedge clk);
      test_illegal_start_reset();
      test_back_to_back();
      @(negedge clk);
      test_long_k();
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
